// File: rtl/tls_monitor.sv
// Passive checker for the traffic-light lamp interface: measures every phase,
// reports it, and raises sticky errors for bad lamp patterns, sequences and lengths.
module tls_monitor #(
  parameter int TW = 4,
  parameter int LW = 5,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Set,
  input  logic          Stop,
  input  logic          Jump,
  input  logic [TW-1:0] Gin,
  input  logic [TW-1:0] Yin,
  input  logic [TW-1:0] Rin,
  input  logic          light_r,
  input  logic          light_g,
  input  logic          light_y,
  input  logic          err_clr,
  output logic          phase_valid,
  output logic [1:0]    phase_id,
  output logic [LW-1:0] phase_len,
  output logic          phase_trunc,
  output logic          err_onehot,
  output logic          err_seq,
  output logic          err_len,
  output logic          err_any,
  output logic          armed,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_Y = 2'd2} phase_e;

  phase_e        r_state, w_state_nxt, w_pat;
  logic [LW-1:0] r_len, w_len_nxt, w_len_inc, w_exp;
  logic [TW-1:0] r_g_t, r_y_t, r_r_t, w_g_nxt, w_y_nxt, w_r_nxt;
  logic          w_onehot, w_legal;
  logic          w_ev_onehot, w_ev_seq, w_ev_len;
  logic          w_valid_nxt, w_trunc_nxt, w_armed_nxt;
  logic [1:0]    w_id_nxt;
  logic [LW-1:0] w_plen_nxt;
  logic [CW-1:0] w_cyc_nxt;
  logic          w_eo_nxt, w_es_nxt, w_el_nxt;

  // A programmed duration of zero means the longest phase, 2^TW cycles.
  function automatic logic [LW-1:0] exp_len(input logic [TW-1:0] x);
    return (x == '0) ? LW'(2 ** TW) : LW'(x);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_pat       = PH_Y;
    w_onehot    = 1'b1;
    case ({light_r, light_g, light_y})
      3'b100:  w_pat = PH_R;
      3'b010:  w_pat = PH_G;
      3'b001:  w_pat = PH_Y;
      default: w_onehot = 1'b0;
    endcase

    case (r_state)
      PH_R:    w_exp = exp_len(r_r_t);
      PH_G:    w_exp = exp_len(r_g_t);
      default: w_exp = exp_len(r_y_t);
    endcase

    w_len_inc = (r_len == '1) ? r_len : r_len + LW'(1);
    w_legal   = (r_state == PH_G && w_pat == PH_Y) ||
                (r_state == PH_Y && w_pat == PH_R) ||
                (r_state == PH_R && w_pat == PH_G);

    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_g_nxt     = r_g_t;
    w_y_nxt     = r_y_t;
    w_r_nxt     = r_r_t;
    w_armed_nxt = armed;
    w_cyc_nxt   = cycle_cnt;
    w_valid_nxt = 1'b0;
    w_id_nxt    = phase_id;
    w_plen_nxt  = phase_len;
    w_trunc_nxt = phase_trunc;
    w_ev_onehot = 1'b0;
    w_ev_seq    = 1'b0;
    w_ev_len    = 1'b0;

    if (Set || Jump) begin
      w_valid_nxt = 1'b1;
      w_id_nxt    = r_state;
      w_plen_nxt  = Stop ? r_len : w_len_inc;
      w_trunc_nxt = 1'b1;
      w_len_nxt   = '0;
      w_state_nxt = Set ? PH_G : PH_R;
      if (Set) begin
        w_g_nxt     = Gin;
        w_y_nxt     = Yin;
        w_r_nxt     = Rin;
        w_armed_nxt = 1'b1;
      end
    end else if (!w_onehot) begin
      w_ev_onehot = 1'b1;
    end else if (w_pat == r_state) begin
      if (!Stop) w_len_nxt = w_len_inc;
    end else begin
      w_valid_nxt = 1'b1;
      w_id_nxt    = r_state;
      w_plen_nxt  = r_len;
      w_trunc_nxt = 1'b0;
      if (!w_legal)                  w_ev_seq = 1'b1;
      else if (armed && r_len != w_exp) w_ev_len = 1'b1;
      if (w_legal && armed && r_state == PH_R) w_cyc_nxt = cycle_cnt + CW'(1);
      w_state_nxt = w_pat;
      w_len_nxt   = Stop ? LW'(0) : LW'(1);
    end

    // A fresh error on the clearing edge takes precedence over the clear.
    w_eo_nxt = w_ev_onehot | (err_onehot & ~err_clr);
    w_es_nxt = w_ev_seq    | (err_seq    & ~err_clr);
    w_el_nxt = w_ev_len    | (err_len    & ~err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= PH_G;
      r_len       <= '0;
      r_g_t       <= '0;
      r_y_t       <= '0;
      r_r_t       <= '0;
      phase_valid <= 1'b0;
      phase_id    <= '0;
      phase_len   <= '0;
      phase_trunc <= 1'b0;
      err_onehot  <= 1'b0;
      err_seq     <= 1'b0;
      err_len     <= 1'b0;
      err_any     <= 1'b0;
      armed       <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_g_t       <= w_g_nxt;
      r_y_t       <= w_y_nxt;
      r_r_t       <= w_r_nxt;
      phase_valid <= w_valid_nxt;
      phase_id    <= w_id_nxt;
      phase_len   <= w_plen_nxt;
      phase_trunc <= w_trunc_nxt;
      err_onehot  <= w_eo_nxt;
      err_seq     <= w_es_nxt;
      err_len     <= w_el_nxt;
      err_any     <= w_eo_nxt | w_es_nxt | w_el_nxt;
      armed       <= w_armed_nxt;
      cycle_cnt   <= w_cyc_nxt;
    end
  end

endmodule

// File: tb/tb_tls_monitor.sv
// Bench for tls_monitor: directed lamp scenarios plus a randomized TLS-like lamp
// generator, all checked cycle by cycle against a phase-level reference model.
module tb_tls_monitor;

  localparam int LMAX = 31;  // 2^LW - 1

  logic       clk = 1'b0, reset = 1'b1;
  logic       set = 1'b0, stop = 1'b0, jump = 1'b0, eclr = 1'b0;
  logic [3:0] gin = '0, yin = '0, rin = '0;
  logic       lr = 1'b0, lg = 1'b1, ly = 1'b0;
  logic       phase_valid, phase_trunc, err_onehot, err_seq, err_len, err_any, armed;
  logic [1:0] phase_id;
  logic [4:0] phase_len;
  logic [7:0] cycle_cnt;

  int n_checks = 0, n_errors = 0;

  // Reference model: phase numbers 0=R 1=G 2=Y, durations kept per phase.
  int next_of [3] = '{1, 2, 0};
  int m_dur [3];
  int m_ph, m_len, m_cyc;
  bit m_armed, m_eo, m_es, m_el;
  bit x_valid, x_trunc;
  int x_id, x_len;

  tls_monitor dut (
    .clk(clk), .reset(reset), .Set(set), .Stop(stop), .Jump(jump),
    .Gin(gin), .Yin(yin), .Rin(rin),
    .light_r(lr), .light_g(lg), .light_y(ly), .err_clr(eclr),
    .phase_valid(phase_valid), .phase_id(phase_id), .phase_len(phase_len),
    .phase_trunc(phase_trunc), .err_onehot(err_onehot), .err_seq(err_seq),
    .err_len(err_len), .err_any(err_any), .armed(armed), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int expd(input int d);
    return (d == 0) ? 16 : d;
  endfunction

  function automatic int sat(input int v);
    return (v > LMAX) ? LMAX : v;
  endfunction

  task automatic model_reset();
    m_ph = 1; m_len = 0; m_cyc = 0; m_armed = 0;
    m_eo = 0; m_es = 0; m_el = 0; x_valid = 0;
    m_dur = '{0, 0, 0};
  endtask

  task automatic model_step();
    int  p;
    bit  ev_o, ev_s, ev_l, legal;
    ev_o = 0; ev_s = 0; ev_l = 0; x_valid = 0;
    p = lr ? 0 : (lg ? 1 : 2);
    if (set || jump) begin
      x_valid = 1; x_id = m_ph; x_trunc = 1;
      x_len = sat(m_len + (stop ? 0 : 1));
      m_len = 0;
      if (set) begin
        m_dur = '{int'(rin), int'(gin), int'(yin)};
        m_armed = 1; m_ph = 1;
      end else m_ph = 0;
    end else if (int'(lr) + int'(lg) + int'(ly) != 1) begin
      ev_o = 1;
    end else if (p == m_ph) begin
      if (!stop) m_len = sat(m_len + 1);
    end else begin
      x_valid = 1; x_id = m_ph; x_len = m_len; x_trunc = 0;
      legal = (p == next_of[m_ph]);
      ev_s = !legal;
      ev_l = legal && m_armed && (m_len != expd(m_dur[m_ph]));
      if (legal && m_armed && p == 1) m_cyc = (m_cyc + 1) % 256;
      m_ph = p;
      m_len = stop ? 0 : 1;
    end
    m_eo = ev_o | (m_eo & !eclr);
    m_es = ev_s | (m_es & !eclr);
    m_el = ev_l | (m_el & !eclr);
  endtask

  task automatic set_lamps(input int ph);
    {lr, lg, ly} = (ph == 0) ? 3'b100 : (ph == 1) ? 3'b010 : 3'b001;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    check("valid", phase_valid, x_valid);
    if (x_valid) begin
      check("id", phase_id, x_id);
      check("len", phase_len, x_len);
      check("trunc", phase_trunc, x_trunc);
    end
    check("err_onehot", err_onehot, m_eo);
    check("err_seq", err_seq, m_es);
    check("err_len", err_len, m_el);
    check("err_any", err_any, m_eo | m_es | m_el);
    check("armed", armed, m_armed);
    check("cycle_cnt", cycle_cnt, m_cyc);
  endtask

  task automatic phase(input int ph, input int n);
    set_lamps(ph);
    repeat (n) tick();
  endtask

  task automatic exp_rep(input string tag, input int id, input int len, input int tr);
    check({tag, "_valid"}, phase_valid, 1);
    check({tag, "_id"}, phase_id, id);
    check({tag, "_len"}, phase_len, len);
    check({tag, "_trunc"}, phase_trunc, tr);
  endtask

  task automatic do_set(input int g, input int y, input int r);
    set = 1; gin = 4'(g); yin = 4'(y); rin = 4'(r);
    tick();
    set = 0;
  endtask

  initial begin
    int g_ph, g_left;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", phase_valid, 0);
    check("rst_err_any", err_any, 0);
    check("rst_armed", armed, 0);
    check("rst_cycle", cycle_cnt, 0);
    reset = 0;

    // Normal programmed cycle.
    do_set(3, 2, 4);
    phase(1, 3); phase(2, 1); exp_rep("g3", 1, 3, 0);
    phase(2, 1); phase(0, 1); exp_rep("y2", 2, 2, 0);
    phase(0, 3); phase(1, 1); exp_rep("r4", 0, 4, 0);
    check("cyc1", cycle_cnt, 1);
    check("clean_any", err_any, 0);

    // Stop stretches Green without changing its counted length.
    do_set(3, 2, 4);
    set_lamps(1); tick(); stop = 1; tick(); tick(); stop = 0; tick(); tick();
    phase(2, 1); exp_rep("stop_g", 1, 3, 0);
    check("stop_err_len", err_len, 0);
    phase(2, 1); phase(0, 4); phase(1, 1);

    // Jump at Green len=1 truncates and forces Red.
    jump = 1; tick(); jump = 0;
    exp_rep("jump", 1, 2, 1);
    phase(0, 4); phase(1, 1); exp_rep("jump_r", 0, 4, 0);
    check("jump_seq", err_seq, 0);
    check("jump_len", err_len, 0);

    // Illegal G->R, then clear.
    phase(1, 2); phase(0, 1);
    check("gr_seq", err_seq, 1);
    check("gr_any", err_any, 1);
    eclr = 1; tick(); eclr = 0;
    check("clr_seq", err_seq, 0);
    check("clr_any", err_any, 0);

    // Two lamps lit: error only, Red length keeps counting afterwards.
    {lr, lg, ly} = 3'b110; tick();
    check("oh_err", err_onehot, 1);
    phase(0, 2); phase(1, 1); exp_rep("oh_r", 0, 4, 0);
    eclr = 1; tick(); eclr = 0;

    // Zero duration means 16; overlong Red flags err_len; reset mid-Red.
    do_set(0, 2, 4);
    phase(1, 16); phase(2, 1); exp_rep("g16", 1, 16, 0);
    check("g16_len", err_len, 0);
    phase(2, 1); phase(0, 5); phase(1, 1); exp_rep("r5", 0, 5, 0);
    check("r5_len", err_len, 1);
    phase(1, 3); phase(2, 2); phase(0, 2);
    #3 reset = 1; #1;
    check("arst_valid", phase_valid, 0);
    check("arst_err", err_any, 0);
    check("arst_armed", armed, 0);
    check("arst_cycle", cycle_cnt, 0);
    model_reset();
    @(posedge clk); #1 reset = 0;

    // Unarmed long Green saturates the length counter.
    phase(1, 40); phase(2, 1); exp_rep("sat", 1, LMAX, 0);
    check("sat_len", err_len, 0);

    // Randomized TLS-like traffic with occasional glitches and slips.
    g_ph = 2; g_left = 3;
    repeat (3000) begin
      set  = ($urandom_range(0, 63) == 0);
      jump = !set && ($urandom_range(0, 63) == 0);
      stop = ($urandom_range(0, 3) == 0);
      eclr = ($urandom_range(0, 31) == 0);
      if (set) begin gin = 4'($urandom); yin = 4'($urandom); rin = 4'($urandom); end
      if ($urandom_range(0, 39) == 0) {lr, lg, ly} = 3'($urandom);
      else set_lamps(g_ph);
      tick();
      if (set) begin
        g_ph = 1; g_left = expd(int'(gin));
      end else if (jump) begin
        g_ph = 0; g_left = expd(m_dur[0]);
      end else if (!stop) begin
        g_left--;
        if (g_left <= 0) begin
          g_ph = next_of[g_ph];
          g_left = expd(m_dur[g_ph]) + (($urandom_range(0, 15) == 0) ? 1 : 0);
        end
      end
    end
    set = 0; jump = 0; stop = 0; eclr = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
